// File: rtl/module_secuenciador.sv
// Two-operand capture sequencer driving an 8x8 signed-magnitude shift-and-add multiplier.
// All outputs are registered so they can feed the display priority selector directly.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ESPERA_1 | idle, waiting for the carga that confirms operand 1
// ESPERA_2 | operand 1 held, waiting for the carga that confirms operand 2
// MULT     | eight shift-and-add iterations, ocupado high
// HECHO    | product valid (listo high), held until carga or borrar
module module_secuenciador (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  num_in,
  input  logic        sig_in,
  input  logic        carga,
  input  logic        borrar,
  output logic [7:0]  num_1,
  output logic [7:0]  num_2,
  output logic        sig_1,
  output logic        sig_2,
  output logic        listo_1,
  output logic        listo_2,
  output logic        listo,
  output logic [15:0] num_mul,
  output logic        sig_mul,
  output logic        ocupado
);

  localparam logic [1:0] ESPERA_1 = 2'd0;
  localparam logic [1:0] ESPERA_2 = 2'd1;
  localparam logic [1:0] MULT     = 2'd2;
  localparam logic [1:0] HECHO    = 2'd3;

  logic [1:0]  state;
  logic [2:0]  cnt;
  logic [15:0] acc;
  logic [15:0] partial;
  logic [15:0] acc_sum;

  // One partial product per iteration: operand 1 weighted by bit cnt of operand 2.
  always_comb begin
    partial = 16'd0;
    if (num_2[cnt]) begin
      partial = {8'd0, num_1} << cnt;
    end
    acc_sum = acc + partial;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ESPERA_1;
      cnt     <= 3'd0;
      acc     <= 16'd0;
      num_1   <= 8'd0;
      num_2   <= 8'd0;
      sig_1   <= 1'b0;
      sig_2   <= 1'b0;
      listo_1 <= 1'b0;
      listo_2 <= 1'b0;
      listo   <= 1'b0;
      num_mul <= 16'd0;
      sig_mul <= 1'b0;
      ocupado <= 1'b0;
    end else if (borrar) begin
      state   <= ESPERA_1;
      cnt     <= 3'd0;
      acc     <= 16'd0;
      num_1   <= 8'd0;
      num_2   <= 8'd0;
      sig_1   <= 1'b0;
      sig_2   <= 1'b0;
      listo_1 <= 1'b0;
      listo_2 <= 1'b0;
      listo   <= 1'b0;
      num_mul <= 16'd0;
      sig_mul <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      case (state)
        ESPERA_1: begin
          if (carga) begin
            num_1   <= num_in;
            sig_1   <= sig_in;
            listo_1 <= 1'b1;
            state   <= ESPERA_2;
          end
        end
        ESPERA_2: begin
          if (carga) begin
            num_2   <= num_in;
            sig_2   <= sig_in;
            listo_2 <= 1'b1;
            acc     <= 16'd0;
            cnt     <= 3'd0;
            ocupado <= 1'b1;
            state   <= MULT;
          end
        end
        MULT: begin
          acc <= acc_sum;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            num_mul <= acc_sum;
            // A zero product is always reported positive.
            sig_mul <= (sig_1 ^ sig_2) & (acc_sum != 16'd0);
            listo   <= 1'b1;
            ocupado <= 1'b0;
            state   <= HECHO;
          end
        end
        HECHO: begin
          if (carga) begin
            num_1   <= num_in;
            sig_1   <= sig_in;
            listo_1 <= 1'b1;
            listo_2 <= 1'b0;
            listo   <= 1'b0;
            num_mul <= 16'd0;
            sig_mul <= 1'b0;
            state   <= ESPERA_2;
          end
        end
        default: begin
          state <= ESPERA_1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_module_secuenciador.sv
// Self-checking bench for module_secuenciador: directed scenarios followed by random
// carga/borrar traffic, compared every cycle against a transaction-level reference model.
module tb_module_secuenciador;

  logic        clk;
  logic        rst;
  logic [7:0]  num_in;
  logic        sig_in;
  logic        carga;
  logic        borrar;
  logic [7:0]  num_1;
  logic [7:0]  num_2;
  logic        sig_1;
  logic        sig_2;
  logic        listo_1;
  logic        listo_2;
  logic        listo;
  logic [15:0] num_mul;
  logic        sig_mul;
  logic        ocupado;

  module_secuenciador dut (
    .clk     (clk),
    .rst     (rst),
    .num_in  (num_in),
    .sig_in  (sig_in),
    .carga   (carga),
    .borrar  (borrar),
    .num_1   (num_1),
    .num_2   (num_2),
    .sig_1   (sig_1),
    .sig_2   (sig_2),
    .listo_1 (listo_1),
    .listo_2 (listo_2),
    .listo   (listo),
    .num_mul (num_mul),
    .sig_mul (sig_mul),
    .ocupado (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: phase 0 waiting op1, 1 waiting op2, 2 multiplying, 3 result shown.
  int          m_phase;
  int          m_left;
  logic [7:0]  m_n1, m_n2;
  logic        m_s1, m_s2, m_l1, m_l2, m_listo, m_smul, m_busy;
  logic [15:0] m_mul;

  task automatic model_clear();
    m_phase = 0; m_left = 0;
    m_n1 = 0; m_n2 = 0; m_s1 = 0; m_s2 = 0;
    m_l1 = 0; m_l2 = 0; m_listo = 0; m_mul = 0; m_smul = 0; m_busy = 0;
  endtask

  task automatic model_edge(input logic c, input logic b, input logic [7:0] n, input logic s);
    int prod;
    if (b) begin
      model_clear();
    end else if (m_phase == 0) begin
      if (c) begin m_n1 = n; m_s1 = s; m_l1 = 1; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (c) begin m_n2 = n; m_s2 = s; m_l2 = 1; m_busy = 1; m_left = 8; m_phase = 2; end
    end else if (m_phase == 2) begin
      m_left--;
      if (m_left == 0) begin
        prod    = int'(m_n1) * int'(m_n2);
        m_mul   = prod[15:0];
        m_smul  = (prod != 0) && (m_s1 != m_s2);
        m_listo = 1; m_busy = 0; m_phase = 3;
      end
    end else begin
      if (c) begin
        m_n1 = n; m_s1 = s; m_l1 = 1; m_l2 = 0; m_listo = 0; m_mul = 0; m_smul = 0;
        m_phase = 1;
      end
    end
  endtask

  task automatic check_all(input string w);
    chk({w, ".num_1"},   32'(num_1),   32'(m_n1));
    chk({w, ".num_2"},   32'(num_2),   32'(m_n2));
    chk({w, ".sig_1"},   32'(sig_1),   32'(m_s1));
    chk({w, ".sig_2"},   32'(sig_2),   32'(m_s2));
    chk({w, ".listo_1"}, 32'(listo_1), 32'(m_l1));
    chk({w, ".listo_2"}, 32'(listo_2), 32'(m_l2));
    chk({w, ".listo"},   32'(listo),   32'(m_listo));
    chk({w, ".num_mul"}, 32'(num_mul), 32'(m_mul));
    chk({w, ".sig_mul"}, 32'(sig_mul), 32'(m_smul));
    chk({w, ".ocupado"}, 32'(ocupado), 32'(m_busy));
  endtask

  task automatic step(input string w, input logic c, input logic b,
                      input logic [7:0] n, input logic s);
    @(negedge clk);
    carga = c; borrar = b; num_in = n; sig_in = s;
    @(posedge clk);
    model_edge(c, b, n, s);
    #1;
    check_all(w);
  endtask

  task automatic idle(input string w, input int k);
    for (int i = 0; i < k; i++) step(w, 1'b0, 1'b0, 8'($urandom), 1'($urandom));
  endtask

  int lat;

  initial begin
    rst = 1'b0; carga = 0; borrar = 0; num_in = 0; sig_in = 0;
    model_clear();
    #12;
    check_all("reset");
    @(negedge clk); rst = 1'b1;
    idle("after_reset", 2);

    // 15(+) x 10(-) = 150, negative
    step("op1_15", 1, 0, 8'd15, 0);
    step("op2_10", 1, 0, 8'd10, 1);
    idle("mult_15x10", 9);
    chk("basic.num_mul", 32'(num_mul), 32'd150);
    chk("basic.sig_mul", 32'(sig_mul), 32'd1);

    // 255(-) x 255(-) with explicit latency measurement
    step("clr", 0, 1, 0, 0);
    step("op1_255", 1, 0, 8'd255, 1);
    step("op2_255", 1, 0, 8'd255, 1);
    lat = 0;
    while (listo !== 1'b1 && lat < 20) begin idle("mult_max", 1); lat++; end
    chk("max.latency", 32'(lat), 32'd8);
    chk("max.num_mul", 32'(num_mul), 32'd65025);
    chk("max.sig_mul", 32'(sig_mul), 32'd0);

    // 0(-) x 37(+): zero product is never negative
    step("clr", 0, 1, 0, 0);
    step("op1_0", 1, 0, 8'd0, 1);
    step("op2_37", 1, 0, 8'd37, 0);
    idle("mult_zero", 9);
    chk("zero.num_mul", 32'(num_mul), 32'd0);
    chk("zero.sig_mul", 32'(sig_mul), 32'd0);

    // Chaining: carga 3(+) while result is shown
    step("chain_op1", 1, 0, 8'd3, 0);
    chk("chain.num_1", 32'(num_1), 32'd3);
    chk("chain.listo", 32'(listo), 32'd0);

    // carga ignored during MULT, borrar at MULT cycle 4 aborts
    step("op2_abort", 1, 0, 8'd7, 1);
    step("mult_carga", 1, 0, 8'd99, 1);
    step("mult_carga", 1, 0, 8'd42, 0);
    chk("ignore.num_1", 32'(num_1), 32'd3);
    chk("ignore.num_2", 32'(num_2), 32'd7);
    step("mult_c3", 0, 0, 0, 0);
    step("borrar_c4", 1, 1, 8'd5, 1);
    chk("abort.num_1", 32'(num_1), 32'd0);
    idle("after_abort", 12);
    chk("abort.listo", 32'(listo), 32'd0);

    // Async reset pulsed between edges in the middle of MULT
    step("op1_9", 1, 0, 8'd9, 0);
    step("op2_11", 1, 0, 8'd11, 1);
    idle("mult_pre_rst", 3);
    #2 rst = 1'b0;
    #1;
    model_clear();
    check_all("async_rst");
    #1 rst = 1'b1;
    idle("after_async", 12);
    chk("async.listo", 32'(listo), 32'd0);
    step("op1_post_rst", 1, 0, 8'd21, 1);
    chk("post_rst.num_1", 32'(num_1), 32'd21);
    chk("post_rst.listo_2", 32'(listo_2), 32'd0);

    // Random traffic, including held carga and occasional borrar
    for (int i = 0; i < 600; i++) begin
      logic [7:0] n;
      n = 8'($urandom);
      if ($urandom_range(0, 9) == 0) n = 8'd0;
      else if ($urandom_range(0, 9) == 0) n = 8'd255;
      step("rand", 1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 3),
           n, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/module_secuenciador.md
MODULE_SECUENCIADOR -- requirements
Module: module_secuenciador

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 num_in  in  8  operand magnitude from the entry logic.
REQ-005 sig_in  in  1  operand sign; 1 = negative.
REQ-006 carga  in  1  one-cycle pulse confirming num_in/sig_in as the next operand.
REQ-007 borrar  in  1  one-cycle pulse that aborts and clears the operation.
REQ-008 num_1, num_2  out  8 each  latched operand magnitudes.
REQ-009 sig_1, sig_2  out  1 each  latched operand signs.
REQ-010 listo_1, listo_2  out  1 each  operand 1 / operand 2 captured.
REQ-011 listo  out  1  product valid.
REQ-012 num_mul  out  16  product magnitude.
REQ-013 sig_mul  out  1  product sign.
REQ-014 ocupado  out  1  high while the multiplication runs.
REQ-015 SHALL keep all outputs registered, so they can feed the display priority selector directly.

Function
REQ-016 The FSM SHALL have four states: ESPERA_1, ESPERA_2, MULT, HECHO.
REQ-017 ESPERA_1 + carga: latch num_1/sig_1, set listo_1=1, go to ESPERA_2.
REQ-018 ESPERA_2 + carga: latch num_2/sig_2, set listo_2=1, clear the accumulator and the 3-bit iteration counter, go to MULT.
REQ-019 MULT: ocupado=1; each cycle, if num_2[cnt]=1, add ({8'b0,num_1} << cnt) to the 16-bit accumulator; cnt increments.
REQ-020 MULT SHALL run exactly 8 cycles (cnt 0..7); on the edge completing cnt=7, load num_mul, set listo=1, clear ocupado, go to HECHO.
REQ-021 Latency SHALL be fixed: listo rises on the 8th rising edge after the edge that samples the second carga.
REQ-022 The result SHALL be num_mul = num_1*num_2 exactly; 8x8 magnitudes fit 16 bits, so no overflow is possible.
REQ-023 sig_mul SHALL equal sig_1 XOR sig_2, except that sig_mul=0 when num_mul=0 (no negative zero).
REQ-024 num_mul/sig_mul SHALL keep their previous value until listo rises; they are valid only while listo=1.
REQ-025 HECHO SHALL hold all outputs until carga or borrar.
REQ-026 HECHO + carga: latch a new num_1/sig_1, set listo_1=1, clear listo_2/listo/num_mul/sig_mul, go to ESPERA_2.
REQ-027 carga during MULT SHALL be ignored; the operands do not change.
REQ-028 borrar in any state: next edge clears all outputs to 0 and goes to ESPERA_1.
REQ-029 borrar SHALL take priority over a simultaneous carga.
REQ-030 A carga pulse held high for several cycles SHALL be treated as separate confirmations (no edge detection inside this block).

Reset
REQ-031 rst=0 SHALL immediately force state ESPERA_1, cnt=0, accumulator=0, and every output to 0, regardless of clk.
REQ-032 Reset asserted mid-MULT SHALL abort the operation; listo SHALL not rise after release.
REQ-033 After rst returns high, the first carga SHALL be taken as operand 1.

Verification
REQ-034 Reset: rst=0 then 1 -> all outputs 0; ocupado=0; state ESPERA_1.
REQ-035 Basic product: carga 15(+), then carga 10(-) -> listo_1, then listo_2; ocupado for 8 cycles; listo=1 with num_mul=150, sig_mul=1.
REQ-036 Maximum values: 255(-) x 255(-) -> num_mul=65025, sig_mul=0, listo exactly 8 edges after the second carga.
REQ-037 Zero result: 0(-) x 37(+) -> num_mul=0, sig_mul=0.
REQ-038 Ignore and abort: carga during MULT -> num_1/num_2 unchanged; borrar at MULT cycle 4 -> all outputs 0 next cycle; listo never rises.
REQ-039 Chaining and async reset: carga 3(+) in HECHO -> num_1=3, listo_1=1, listo_2=listo=0, state ESPERA_2; rst pulsed low between clock edges mid-MULT -> outputs clear without a clock edge.
